// File: rtl/phase16_pkg.sv
// Shared definitions for 16-phase thermometer/Johnson phase blocks.
package phase16_pkg;

  localparam int PHASE_W    = 16;
  localparam int IDX_W      = 5;
  localparam int NUM_PHASES = 32;

  // Lock tracker state.
  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // Number of ones in a 16-bit word (0..16 fits in 5 bits).
  function automatic logic [IDX_W-1:0] popcount16(input logic [PHASE_W-1:0] w);
    logic [IDX_W-1:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < PHASE_W; i++) begin
      cnt = cnt + {4'd0, w[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/thermo_decode_16.sv
// Combinational decoder: 16-bit thermometer/Johnson word -> 5-bit phase index.
// Low form (ones packed at the LSB end) maps to its popcount 0..16.
// High form (ones packed at the MSB end, 1..15 of them) maps to 32 - popcount,
// i.e. 17..31. Everything else is not a legal phase word.
module thermo_decode_16
  import phase16_pkg::*;
(
  input  logic [PHASE_W-1:0] word_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               legal_o
);

  logic [PHASE_W-1:0] inv_s;
  logic [IDX_W-1:0]   pop_s;
  logic [5:0]         high_idx_s;
  logic               low_form_s;
  logic               high_form_s;

  // Classify the word and compute its index.
  always_comb begin
    inv_s       = ~word_i;
    pop_s       = popcount16(word_i);
    low_form_s  = ((word_i & (word_i + 16'd1)) == 16'd0);
    // 0x0000 and 0xFFFF are already low form, so the inverted test only
    // needs to cover the words with 1..15 ones.
    high_form_s = ((inv_s & (inv_s + 16'd1)) == 16'd0) &&
                  (pop_s != 5'd0) && (pop_s != 5'd16);
    high_idx_s  = 6'd32 - {1'b0, pop_s};
    if (low_form_s) begin
      idx_o   = pop_s;
      legal_o = 1'b1;
    end else if (high_form_s) begin
      idx_o   = high_idx_s[IDX_W-1:0];
      legal_o = 1'b1;
    end else begin
      idx_o   = 5'd0;
      legal_o = 1'b0;
    end
  end

endmodule

// File: rtl/phase_decoder_16.sv
// Receive-side phase word checker: registers the generator's thermometer word,
// decodes it to a phase index, flags illegal words and out-of-sequence steps,
// tracks lock and keeps a saturating error count. Outputs appear two edges
// after the word is presented.
module phase_decoder_16
  import phase16_pkg::*;
#(
  parameter int LOCK_COUNT  = 8,
  parameter int UNLOCK_ERRS = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_gen_n,
  input  logic [PHASE_W-1:0]   phase_in,
  input  logic                 clr_err,
  output logic [IDX_W-1:0]     phase_idx,
  output logic                 idx_valid,
  output logic                 code_err,
  output logic                 seq_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [7:0]           LOCK_CNT_C = 8'(LOCK_COUNT);
  localparam logic [3:0]           UNLOCK_C   = 4'(UNLOCK_ERRS);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX_C  = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE_C  = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] ERR_ZERO_C = {ERR_CNT_W{1'b0}};

  // Input stage; phase_vld_q keeps the reset value of phase_q from being
  // decoded as a real 0x0000 word.
  logic [PHASE_W-1:0]   phase_q;
  logic                 phase_vld_q;

  logic [IDX_W-1:0]     phase_idx_q, phase_idx_d;
  logic                 idx_valid_q, idx_valid_d;
  logic                 code_err_q, code_err_d;
  logic                 seq_err_q, seq_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [IDX_W-1:0]     prev_idx_q, prev_idx_d;
  logic                 prev_valid_q, prev_valid_d;
  logic [7:0]           run_q, run_d;
  logic [3:0]           miss_q, miss_d;
  lock_state_e          state_q, state_d;

  logic [IDX_W-1:0]     dec_idx_s;
  logic                 dec_legal_s;
  logic [IDX_W-1:0]     exp_idx_s;
  logic                 good_s;
  logic                 bad_s;

  thermo_decode_16 u_dec (
    .word_i  (phase_q),
    .idx_o   (dec_idx_s),
    .legal_o (dec_legal_s)
  );

  // Classify the registered word and update the sequence history.
  always_comb begin
    phase_idx_d  = phase_idx_q;
    idx_valid_d  = 1'b0;
    code_err_d   = 1'b0;
    seq_err_d    = 1'b0;
    prev_idx_d   = prev_idx_q;
    prev_valid_d = prev_valid_q;
    good_s       = 1'b0;
    bad_s        = 1'b0;
    exp_idx_s    = prev_idx_q + 5'd1;
    if (phase_vld_q) begin
      if (dec_legal_s) begin
        idx_valid_d  = 1'b1;
        phase_idx_d  = dec_idx_s;
        if (prev_valid_q && (dec_idx_s != exp_idx_s)) begin
          seq_err_d = 1'b1;
          bad_s     = 1'b1;
        end else begin
          good_s    = prev_valid_q;
        end
        prev_idx_d   = dec_idx_s;
        prev_valid_d = 1'b1;
      end else begin
        // Illegal word: hold the index and restart sequence checking.
        code_err_d   = 1'b1;
        bad_s        = 1'b1;
        prev_valid_d = 1'b0;
      end
    end else begin
      prev_valid_d = prev_valid_q;
    end
  end

  // Lock FSM next state: count good steps in SEARCH, bad steps in LOCKED.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    miss_d  = miss_q;
    case (state_q)
      SEARCH: begin
        if (good_s) begin
          if ((run_q + 8'd1) == LOCK_CNT_C) begin
            state_d = LOCKED;
            run_d   = 8'd0;
          end else begin
            run_d   = run_q + 8'd1;
          end
        end else if (bad_s) begin
          run_d = 8'd0;
        end else begin
          run_d = run_q;
        end
      end
      LOCKED: begin
        if (bad_s) begin
          if ((miss_q + 4'd1) == UNLOCK_C) begin
            state_d = SEARCH;
            miss_d  = 4'd0;
            run_d   = 8'd0;
          end else begin
            miss_d  = miss_q + 4'd1;
          end
        end else if (good_s) begin
          miss_d = 4'd0;
        end else begin
          miss_d = miss_q;
        end
      end
      default: begin
        state_d = SEARCH;
        run_d   = 8'd0;
        miss_d  = 4'd0;
      end
    endcase
  end

  // Saturating error counter; a clear coinciding with a bad step keeps that step.
  always_comb begin
    err_count_d = err_count_q;
    if (clr_err) begin
      err_count_d = bad_s ? ERR_ONE_C : ERR_ZERO_C;
    end else if (bad_s && (err_count_q != ERR_MAX_C)) begin
      err_count_d = err_count_q + ERR_ONE_C;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_gen_n) begin
    if (!rst_gen_n) begin
      phase_q      <= 16'h0000;
      phase_vld_q  <= 1'b0;
      phase_idx_q  <= 5'd0;
      idx_valid_q  <= 1'b0;
      code_err_q   <= 1'b0;
      seq_err_q    <= 1'b0;
      err_count_q  <= ERR_ZERO_C;
      prev_idx_q   <= 5'd0;
      prev_valid_q <= 1'b0;
      run_q        <= 8'd0;
      miss_q       <= 4'd0;
      state_q      <= SEARCH;
    end else begin
      phase_q      <= phase_in;
      phase_vld_q  <= 1'b1;
      phase_idx_q  <= phase_idx_d;
      idx_valid_q  <= idx_valid_d;
      code_err_q   <= code_err_d;
      seq_err_q    <= seq_err_d;
      err_count_q  <= err_count_d;
      prev_idx_q   <= prev_idx_d;
      prev_valid_q <= prev_valid_d;
      run_q        <= run_d;
      miss_q       <= miss_d;
      state_q      <= state_d;
    end
  end

  assign phase_idx = phase_idx_q;
  assign idx_valid = idx_valid_q;
  assign code_err  = code_err_q;
  assign seq_err   = seq_err_q;
  assign locked    = (state_q == LOCKED);
  assign err_count = err_count_q;

endmodule

// File: tb/tb_phase_decoder_16.sv
// Directed self-checking bench for phase_decoder_16 (LOCK_COUNT=8,
// UNLOCK_ERRS=2, ERR_CNT_W=8).
module tb_phase_decoder_16;

  logic        clk;
  logic        rst_gen_n;
  logic [15:0] phase_in;
  logic        clr_err;
  logic [4:0]  phase_idx;
  logic        idx_valid;
  logic        code_err;
  logic        seq_err;
  logic        locked;
  logic [7:0]  err_count;

  int n_tests;
  int n_fail;

  phase_decoder_16 #(
    .LOCK_COUNT  (8),
    .UNLOCK_ERRS (2),
    .ERR_CNT_W   (8)
  ) dut (
    .clk       (clk),
    .rst_gen_n (rst_gen_n),
    .phase_in  (phase_in),
    .clr_err   (clr_err),
    .phase_idx (phase_idx),
    .idx_valid (idx_valid),
    .code_err  (code_err),
    .seq_err   (seq_err),
    .locked    (locked),
    .err_count (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the observed value differs.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Generator code word for phase index k (0..31).
  function automatic logic [15:0] thermo(input int k);
    logic [31:0] t;
    if (k <= 16) begin
      t = (32'd1 << k) - 32'd1;
      return t[15:0];
    end else begin
      t = (32'd1 << (k - 16)) - 32'd1;
      return ~t[15:0];
    end
  endfunction

  // Present a raw word for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic feed_raw(input logic [15:0] w);
    phase_in = w;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int k);
    feed_raw(thermo(k));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_idx"},  {27'd0, phase_idx}, 32'd0);
    check_eq({tag, "_vld"},  {31'd0, idx_valid}, 32'd0);
    check_eq({tag, "_cerr"}, {31'd0, code_err},  32'd0);
    check_eq({tag, "_serr"}, {31'd0, seq_err},   32'd0);
    check_eq({tag, "_lock"}, {31'd0, locked},    32'd0);
    check_eq({tag, "_ecnt"}, {24'd0, err_count}, 32'd0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_gen_n = 1'b0;
    phase_in  = 16'h0000;
    clr_err   = 1'b0;

    // Reset state, then a constant 0x0000 stream.
    #2;
    check_all_zero("rst");
    #1 rst_gen_n = 1'b1;
    feed_raw(16'h0000);
    check_eq("zero_lat1_vld", {31'd0, idx_valid}, 32'd0);
    feed_raw(16'h0000);
    check_eq("zero_first_vld", {31'd0, idx_valid}, 32'd1);
    check_eq("zero_first_idx", {27'd0, phase_idx}, 32'd0);
    check_eq("zero_first_serr", {31'd0, seq_err}, 32'd0);
    feed_raw(16'h0000);
    check_eq("zero_second_serr", {31'd0, seq_err}, 32'd1);
    check_eq("zero_second_ecnt", {24'd0, err_count}, 32'd1);
    for (int i = 0; i < 3; i++) feed_raw(16'h0000);
    check_eq("zero_ecnt4", {24'd0, err_count}, 32'd4);
    check_eq("zero_lock", {31'd0, locked}, 32'd0);

    // Generator sequence 0,0,1,2,...,31,0,1,...
    @(negedge clk) rst_gen_n = 1'b0;
    @(negedge clk) rst_gen_n = 1'b1;
    for (int j = 0; j <= 40; j++) begin
      feed((j == 0) ? 0 : ((j - 1) % 32));
      if (j >= 1) begin
        check_eq("gen_idx",  {27'd0, phase_idx},
                 (j - 1 == 0) ? 32'd0 : 32'((j - 2) % 32));
        check_eq("gen_vld",  {31'd0, idx_valid}, 32'd1);
        check_eq("gen_serr", {31'd0, seq_err}, (j - 1 == 1) ? 32'd1 : 32'd0);
        check_eq("gen_lock", {31'd0, locked},  (j - 1 >= 9) ? 32'd1 : 32'd0);
      end
    end
    check_eq("gen_ecnt", {24'd0, err_count}, 32'd1);

    // Illegal word while locked (last fed index was 7).
    feed_raw(16'h00F0);
    check_eq("ill_pre_idx", {27'd0, phase_idx}, 32'd7);
    feed(8);
    check_eq("ill_cerr", {31'd0, code_err},  32'd1);
    check_eq("ill_vld",  {31'd0, idx_valid}, 32'd0);
    check_eq("ill_hold", {27'd0, phase_idx}, 32'd7);
    check_eq("ill_lock", {31'd0, locked},    32'd1);
    check_eq("ill_ecnt", {24'd0, err_count}, 32'd2);
    feed(9);
    check_eq("ill_next_serr", {31'd0, seq_err},  32'd0);
    check_eq("ill_next_cerr", {31'd0, code_err}, 32'd0);
    check_eq("ill_next_idx",  {27'd0, phase_idx}, 32'd8);
    feed(10);
    feed(11);

    // Two skip steps 11 -> 13 -> 15: first keeps lock (miss cleared earlier).
    feed(13);
    feed(15);
    check_eq("skip1_serr", {31'd0, seq_err}, 32'd1);
    check_eq("skip1_lock", {31'd0, locked},  32'd1);
    feed(16);
    check_eq("skip2_serr", {31'd0, seq_err}, 32'd1);
    check_eq("skip2_lock", {31'd0, locked},  32'd0);
    check_eq("skip2_ecnt", {24'd0, err_count}, 32'd4);
    for (int k = 17; k <= 24; k++) begin
      feed(k);
      check_eq("relock", {31'd0, locked}, (k == 24) ? 32'd1 : 32'd0);
    end

    // Saturate the error counter with repeated zeros.
    for (int i = 0; i < 305; i++) feed(0);
    check_eq("sat_ecnt", {24'd0, err_count}, 32'd255);
    check_eq("sat_lock", {31'd0, locked}, 32'd0);
    clr_err = 1'b1;
    feed(0);
    check_eq("clr_bad_ecnt", {24'd0, err_count}, 32'd1);
    clr_err = 1'b0;
    feed(1);
    check_eq("after_clr_ecnt", {24'd0, err_count}, 32'd2);
    clr_err = 1'b1;
    feed(2);
    check_eq("clr_good_ecnt", {24'd0, err_count}, 32'd0);
    clr_err = 1'b0;
    feed(3);
    check_eq("post_clr_ecnt", {24'd0, err_count}, 32'd0);

    // Relock, then asynchronous reset between clock edges.
    for (int k = 4; k <= 11; k++) feed(k);
    check_eq("pre_rst_lock", {31'd0, locked}, 32'd1);
    check_eq("pre_rst_idx", {27'd0, phase_idx}, 32'd10);
    #2 rst_gen_n = 1'b0;
    #1;
    check_all_zero("arst");
    @(negedge clk) rst_gen_n = 1'b1;
    feed(12);
    check_eq("arst_rel_vld",  {31'd0, idx_valid}, 32'd0);
    check_eq("arst_rel_lock", {31'd0, locked},    32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_decoder_16.md
Name: phase_decoder_16

Overview:
- Receive-side counterpart of the 16-bit thermometer phase generator.
- Samples a 16-bit thermometer/Johnson-coded phase word every clock and decodes it to a 5-bit phase index (0..31).
- Flags illegal code words and out-of-sequence steps, and declares lock after a run of consecutive +1 (mod 32) steps.
- Sits at the CDR phase-select input; the rest of the loop uses it to check generator integrity and derive the selected phase.

Parameters:
- LOCK_COUNT, 8: consecutive good steps needed to enter LOCKED (range 1..255).
- UNLOCK_ERRS, 2: consecutive bad steps in LOCKED that force return to SEARCH (range 1..15).
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_gen_n  in  1  asynchronous, active-low reset.
- phase_in  in  16  thermometer-coded phase word from the generator.
- clr_err  in  1  synchronous clear of err_count.
- phase_idx  out  5  decoded phase index.
- idx_valid  out  1  phase_idx was decoded from a legal word this cycle.
- code_err  out  1  illegal code word this cycle.
- seq_err  out  1  legal word but not previous index +1 mod 32.
- locked  out  1  lock indicator.
- err_count  out  ERR_CNT_W  saturating count of code_err|seq_err cycles.

Behaviour:
- Reset (rst_gen_n=0, asynchronous): all outputs 0; phase_q=0; prev_idx=0; prev_valid=0; run=0; miss=0; FSM=SEARCH.
- Pipeline: phase_in is registered into phase_q at edge N. Decode of phase_q drives all outputs at edge N+1. Latency is 2 edges from phase_in to outputs; throughput is 1 word per cycle.
- Legal words and their index, where p = popcount:
  - Low form, (w & (w+1))==0: idx = p, covering 0..16. 0x0000 gives 0; 0xFFFF gives 16.
  - High form, ~w low form with 1..15 ones: idx = 32 - p, covering 17..31. 0xFFFE gives 17; 0x8000 gives 31.
  - Anything else raises code_err=1 and idx_valid=0.
- On code_err: phase_idx holds its last value and prev_valid is cleared, so the next legal word is not sequence-checked.
- On a legal word:
  - idx_valid=1 and phase_idx=idx.
  - seq_err=1 iff prev_valid and idx != (prev_idx+1) mod 32. A repeated index counts as seq_err. 31 to 0 is a good step.
  - prev_idx is then set to idx and prev_valid to 1.
- Good step: idx_valid & prev_valid(before update) & !seq_err. Bad step: code_err | seq_err. The first legal word after reset or after a code_err is neither good nor bad.
- FSM SEARCH:
  - A good step increments run. When run reaches LOCK_COUNT, go to LOCKED with locked=1 at that same edge, and set run=0.
  - A bad step sets run=0.
- FSM LOCKED:
  - A bad step increments miss. When miss reaches UNLOCK_ERRS, go to SEARCH with locked=0 at that edge, and set miss=0 and run=0.
  - A good step sets miss=0.
- err_count:
  - Increments on each bad step and saturates at all-ones.
  - clr_err alone sets it to 0.
  - clr_err together with a bad step sets it to 1.
- Reset mid-operation: immediate return to reset values; no output glitch is held past deassertion.
- The generator's post-reset sequence (0,0,1,2,…) produces exactly one seq_err on the repeated 0. This is expected behaviour.

Decomposition:
- Shared package phase16_pkg holds:
  - PHASE_W=16, IDX_W=5, NUM_PHASES=32.
  - The FSM state enum {SEARCH, LOCKED}.
- Sub-module thermo_decode_16 (combinational): word in; idx[4:0] and legal out. It is reused by future 16-phase blocks.

Test Plan:
- Reset then drive 0x0000 on every cycle: outputs all 0 for 2 cycles after reset release. Then idx_valid=1 and phase_idx=0. From the 2nd word on, seq_err=1 on every cycle, err_count climbs, and locked stays 0.
- Drive the generator sequence 0,0,1,2,…,31,0,1… (LOCK_COUNT=8):
  - seq_err only on the second 0.
  - locked=1 at the output cycle where phase_idx=8.
  - Step 31 to 0 gives no error.
  - err_count=1.
- While locked, inject one illegal word 0x00F0:
  - code_err=1 for one cycle, phase_idx held, locked stays 1 (miss=1).
  - The next legal word gives no seq_err.
  - Subsequent good steps clear miss.
- While locked, inject two consecutive skip steps (5 to 7 to 9): seq_err=1 twice, then locked=0 at the second error. Relock takes 8 further good steps.
- Drive ERR_CNT_W=8 with 300 bad cycles: err_count saturates at 255. Then clr_err pulsed with a bad step gives err_count=1; clr_err with a good step gives 0.
- Assert rst_gen_n low asynchronously mid-sequence while locked: all outputs 0 immediately, without waiting for a clock edge.
